// File: rtl/serial_display_receiver.sv
// Display-side receiver for the clock's 3-wire shift interface.
// Oversamples data/clock/latch, shifts in a frame and decodes 7-seg to BCD.
module serial_display_receiver #(
    parameter int FRAME_BITS     = 32,
    parameter int NUM_DIGITS     = FRAME_BITS / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ser_data_i,
    input  logic                    ser_clk_i,
    input  logic                    ser_latch_i,
    output logic [FRAME_BITS-1:0]   frame_o,
    output logic [4*NUM_DIGITS-1:0] digit_bcd_o,
    output logic [NUM_DIGITS-1:0]   digit_invalid_o,
    output logic                    frame_valid_o,
    output logic                    frame_error_o
);

    localparam int CNT_W  = $clog2(FRAME_BITS + 2);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FRAME_BITS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic                    r_data_s1;
    logic                    r_data_s2;
    logic [2:0]              r_sclk_s;
    logic [2:0]              r_latch_s;
    logic [FRAME_BITS-1:0]   r_shift_reg;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [IDLE_W-1:0]       r_idle_cnt;

    logic                    w_clk_rise;
    logic                    w_latch_rise;
    logic [FRAME_BITS-1:0]   w_sr_shift;
    logic [CNT_W-1:0]        w_cnt_shift;
    logic [4*NUM_DIGITS-1:0] w_bcd_nxt;
    logic [NUM_DIGITS-1:0]   w_inv_nxt;

    // Returns {invalid, bcd}; blank decodes to 4'hF but is not invalid.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = 5'h00;
            7'h06:   res = 5'h01;
            7'h5B:   res = 5'h02;
            7'h4F:   res = 5'h03;
            7'h66:   res = 5'h04;
            7'h6D:   res = 5'h05;
            7'h7D:   res = 5'h06;
            7'h07:   res = 5'h07;
            7'h7F:   res = 5'h08;
            7'h6F:   res = 5'h09;
            7'h00:   res = 5'h0F;
            default: res = 5'h1F;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_s1 <= 1'b0;
            r_data_s2 <= 1'b0;
            r_sclk_s  <= '0;
            r_latch_s <= '0;
        end else begin
            r_data_s1 <= ser_data_i;
            r_data_s2 <= r_data_s1;
            r_sclk_s  <= {r_sclk_s[1:0], ser_clk_i};
            r_latch_s <= {r_latch_s[1:0], ser_latch_i};
        end
    end

    assign w_clk_rise   = r_sclk_s[1] & ~r_sclk_s[2];
    assign w_latch_rise = r_latch_s[1] & ~r_latch_s[2];

    // Shift is resolved first so a coincident latch sees the new bit.
    always_comb begin
        w_sr_shift  = r_shift_reg;
        w_cnt_shift = r_bit_cnt;
        if (w_clk_rise) begin
            w_sr_shift = (r_shift_reg << 1) | FRAME_BITS'(r_data_s2);
            if (r_bit_cnt != CNT_MAX) begin
                w_cnt_shift = r_bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_bcd_nxt = '0;
        w_inv_nxt = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            {w_inv_nxt[k], w_bcd_nxt[4*k +: 4]} = f_decode(w_sr_shift[8*k +: 7]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift_reg     <= '0;
            r_bit_cnt       <= '0;
            r_idle_cnt      <= '0;
            frame_o         <= '0;
            digit_bcd_o     <= '1;
            digit_invalid_o <= '0;
            frame_valid_o   <= 1'b0;
            frame_error_o   <= 1'b0;
        end else begin
            frame_valid_o <= 1'b0;
            frame_error_o <= 1'b0;
            r_shift_reg   <= w_sr_shift;
            if (w_latch_rise) begin
                r_bit_cnt  <= '0;
                r_idle_cnt <= '0;
                if (w_cnt_shift == CNT_FULL) begin
                    frame_o         <= w_sr_shift;
                    digit_bcd_o     <= w_bcd_nxt;
                    digit_invalid_o <= w_inv_nxt;
                    frame_valid_o   <= 1'b1;
                end else begin
                    frame_error_o <= 1'b1;
                end
            end else if (r_idle_cnt == IDLE_LAST) begin
                r_bit_cnt     <= '0;
                r_idle_cnt    <= '0;
                frame_error_o <= 1'b1;
            end else begin
                r_bit_cnt <= w_cnt_shift;
                if (w_clk_rise || r_bit_cnt == '0) begin
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule
